// File: rtl/sigmoid_pkg.sv
// Shared constants and segment encoding for the PLAN sigmoid pipeline.
// Constants are returned as 32-bit values and narrowed to DW at the point of use.
package sigmoid_pkg;

  typedef enum logic [1:0] {
    SEG_SAT,
    SEG_HI,
    SEG_MID,
    SEG_LO
  } seg_e;

  function automatic logic [31:0] fx_half(input int unsigned frac);
    return 32'(1) << (frac - 1);
  endfunction

  function automatic logic [31:0] fx_0625(input int unsigned frac);
    return 32'(5) << (frac - 3);
  endfunction

  function automatic logic [31:0] fx_084375(input int unsigned frac);
    return 32'(27) << (frac - 5);
  endfunction

  function automatic logic [31:0] fx_one(input int unsigned frac);
    return 32'(1) << frac;
  endfunction

  function automatic logic [31:0] fx_2375(input int unsigned frac);
    return 32'(19) << (frac - 3);
  endfunction

  function automatic logic [31:0] fx_five(input int unsigned frac);
    return 32'(5) << frac;
  endfunction

endpackage

// File: rtl/sigmoid_plan_seg.sv
// Combinational PLAN segment select and linear term: p = f(|x|), shifts and adds only.
module sigmoid_plan_seg
  import sigmoid_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 12
) (
  input  logic [DW-1:0] a_i,
  output logic [DW-1:0] p_o
);

  localparam logic [DW-1:0] C_HALF = DW'(fx_half(FRAC));
  localparam logic [DW-1:0] C_0625 = DW'(fx_0625(FRAC));
  localparam logic [DW-1:0] C_0843 = DW'(fx_084375(FRAC));
  localparam logic [DW-1:0] C_ONE  = DW'(fx_one(FRAC));
  localparam logic [DW-1:0] C_2375 = DW'(fx_2375(FRAC));
  localparam logic [DW-1:0] C_FIVE = DW'(fx_five(FRAC));

  seg_e seg;

  // Lower bounds are inclusive, so exact threshold values land in the upper segment.
  always_comb begin
    seg = SEG_LO;
    if (a_i >= C_FIVE)      seg = SEG_SAT;
    else if (a_i >= C_2375) seg = SEG_HI;
    else if (a_i >= C_ONE)  seg = SEG_MID;

    p_o = '0;
    unique case (seg)
      SEG_SAT: p_o = C_ONE;
      SEG_HI:  p_o = (a_i >> 5) + C_0843;
      SEG_MID: p_o = (a_i >> 3) + C_0625;
      SEG_LO:  p_o = (a_i >> 2) + C_HALF;
      default: p_o = '0;
    endcase
  end

endmodule

// File: rtl/sigmoid_plan_axis.sv
// 3-stage AXI-Stream PLAN sigmoid with full backpressure.
// Optional SIGMOID_STATS_EN adds sat_cnt, counting accepted inputs with |x| >= 5.0.
module sigmoid_plan_axis
  import sigmoid_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 12
) (
`ifdef SIGMOID_STATS_EN
  output logic [15:0]   sat_cnt,
`endif
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready
);

  localparam logic [DW-1:0] C_ONE  = DW'(fx_one(FRAC));
  localparam logic [DW-1:0] C_FIVE = DW'(fx_five(FRAC));

  logic          v1_q, v2_q, v3_q;
  logic          ld1, ld2, ld3;
  logic          sign1_q, sign2_q;
  logic [DW-1:0] a1_d, a1_q;
  logic [DW-1:0] p2_d, p2_q;
  logic [DW-1:0] y3_d, y3_q;

  // Each stage advances when empty or when the stage after it advances.
  always_comb begin
    ld3 = !v3_q || m_axis_tready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
  end

  assign s_axis_tready = ld1;
  assign m_axis_tvalid = v3_q;
  assign m_axis_tdata  = y3_q;

  // Two's-complement magnitude; the most negative input yields 2^(DW-1) unsigned.
  assign a1_d = s_axis_tdata[DW-1] ? (~s_axis_tdata + DW'(1)) : s_axis_tdata;

  sigmoid_plan_seg #(
    .DW  (DW),
    .FRAC(FRAC)
  ) u_seg (
    .a_i(a1_q),
    .p_o(p2_d)
  );

  assign y3_d = sign2_q ? (C_ONE - p2_q) : p2_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      a1_q    <= '0;
      p2_q    <= '0;
      y3_q    <= '0;
    end else begin
      if (ld1) begin
        v1_q    <= s_axis_tvalid;
        sign1_q <= s_axis_tdata[DW-1];
        a1_q    <= a1_d;
      end
      if (ld2) begin
        v2_q    <= v1_q;
        sign2_q <= sign1_q;
        p2_q    <= p2_d;
      end
      if (ld3) begin
        v3_q <= v2_q;
        y3_q <= y3_d;
      end
    end
  end

`ifdef SIGMOID_STATS_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sat_cnt_q <= '0;
    end else if (s_axis_tvalid && ld1 && (a1_d >= C_FIVE) && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule
